// File: rtl/io_port_pkg.sv
// io_port_pkg: address map and debounce state encoding shared by the I/O port controller.
package io_port_pkg;
  localparam logic [3:0] ADDR_INP0   = 4'd0;
  localparam logic [3:0] ADDR_INP1   = 4'd1;
  localparam logic [3:0] ADDR_INP2   = 4'd2;
  localparam logic [3:0] ADDR_INP3   = 4'd3;
  localparam logic [3:0] ADDR_OTP0   = 4'd4;
  localparam logic [3:0] ADDR_OTP1   = 4'd5;
  localparam logic [3:0] ADDR_OTP2   = 4'd6;
  localparam logic [3:0] ADDR_OTP3   = 4'd7;
  localparam logic [3:0] ADDR_STATUS = 4'd8;
  localparam logic [3:0] ADDR_MASK   = 4'd9;
  typedef enum logic {IDLE, COUNT} deb_state_e;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus stability counter that commits a new input word.
module io_debounce
  import io_port_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [DW-1:0] raw_i,
  output logic [DW-1:0] value_o,
  output logic          commit_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  logic [DW-1:0] meta_q, sync_q, prev_q, value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deb_state_e state_q, state_d;
  logic commit;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
  // prev_q holds last cycle's synced word, so a mismatch in COUNT means the candidate moved
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    commit  = 1'b0;
    if (state_q == IDLE) begin
      state_d = (sync_q != value_q) ? COUNT : IDLE;
      cnt_d   = (sync_q != value_q) ? CNT_W'(1) : '0;
    end else if (sync_q == value_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sync_q != prev_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == LAST) begin
      state_d = IDLE;
      cnt_d   = '0;
      value_d = sync_q;
      commit  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  assign value_o  = value_q;
  assign commit_o = commit;
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped input/output ports with debounced inputs, sticky change flags and maskable irq.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          io_sel,
  input  logic          io_we,
  input  logic [3:0]    io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic [DW-1:0] io_rdata,
  output logic          io_rvalid,
  input  logic [DW-1:0] inp0,
  input  logic [DW-1:0] inp1,
  input  logic [DW-1:0] inp2,
  input  logic [DW-1:0] inp3,
  output logic [DW-1:0] otp0,
  output logic [DW-1:0] otp1,
  output logic [DW-1:0] otp2,
  output logic [DW-1:0] otp3,
  output logic          irq
);
  logic [DW-1:0] inp_raw [4];
  logic [DW-1:0] inp_val [4];
  logic [DW-1:0] otp_q [4];
  logic [DW-1:0] otp_d [4];
  logic [DW-1:0] rdata_q, rdata_d, rmux;
  logic [3:0] commit, chg_q, chg_d, mask_q, mask_d;
  logic rvalid_q, irq_q, wr, rd;
  assign inp_raw = '{inp0, inp1, inp2, inp3};
  for (genvar i = 0; i < 4; i++) begin : g_deb
    io_debounce #(.DW(DW), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clock   (clock),
      .resetn  (resetn),
      .raw_i   (inp_raw[i]),
      .value_o (inp_val[i]),
      .commit_o(commit[i])
    );
  end
  assign wr = io_sel & io_we;
  assign rd = io_sel & ~io_we;
  // a commit landing on the same edge as a W1C keeps its flag set
  always_comb begin
    otp_d = otp_q;
    if (wr && io_addr[3:2] == ADDR_OTP0[3:2]) otp_d[io_addr[1:0]] = io_wdata;
    mask_d  = (wr && io_addr == ADDR_MASK) ? io_wdata[3:0] : mask_q;
    chg_d   = (chg_q & ~((wr && io_addr == ADDR_STATUS) ? io_wdata[3:0] : 4'h0)) | commit;
    rmux    = (io_addr[3:2] == ADDR_INP0[3:2]) ? inp_val[io_addr[1:0]] :
              (io_addr[3:2] == ADDR_OTP0[3:2]) ? otp_q[io_addr[1:0]] :
              (io_addr == ADDR_STATUS)         ? DW'(chg_q) :
              (io_addr == ADDR_MASK)           ? DW'(mask_q) : '0;
    rdata_d = rd ? rmux : rdata_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      otp_q    <= '{default: '0};
      mask_q   <= '0;
      chg_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      otp_q    <= otp_d;
      mask_q   <= mask_d;
      chg_q    <= chg_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd;
      irq_q    <= |(chg_q & mask_q);
    end
  end
  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;
  assign irq       = irq_q;
  assign otp0      = otp_q[0];
  assign otp1      = otp_q[1];
  assign otp2      = otp_q[2];
  assign otp3      = otp_q[3];
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and random traffic; a run-length port model feeds a read scoreboard.
module tb_io_port_ctrl;
  localparam int DW  = 32;
  localparam int DEB = 16;
  localparam int LAT = DEB + 2;
  logic clock = 1'b0, resetn = 1'b0, io_sel = 1'b0, io_we = 1'b0, io_rvalid, irq;
  logic [3:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0, io_rdata, otp0, otp1, otp2, otp3;
  logic [DW-1:0] inp [4] = '{default: '0};
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m_val [4], m_last [4], m_otp [4];
  int m_run [4];
  logic [3:0] m_chg, m_mask, m_cm;
  logic m_irq;
  logic [DW-1:0] exp_q [$];

  io_port_ctrl #(.DW(DW), .DEB_CYCLES(DEB), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .inp0(inp[0]), .inp1(inp[1]), .inp2(inp[2]), .inp3(inp[3]),
    .otp0(otp0), .otp1(otp1), .otp2(otp2), .otp3(otp3), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(logic [3:0] a);
    if (a < 4) return m_val[a[1:0]];
    if (a < 8) return m_otp[a[1:0]];
    if (a == 8) return {{(DW-4){1'b0}}, m_chg};
    if (a == 9) return {{(DW-4){1'b0}}, m_mask};
    return '0;
  endfunction

  // reference: a port commits once its raw word has been seen unchanged for LAT consecutive edges
  always @(posedge clock) begin
    if (!resetn) begin
      m_val = '{default: '0};
      m_last = '{default: '0};
      m_otp = '{default: '0};
      m_run = '{default: 0};
      m_chg = '0;
      m_mask = '0;
      m_irq = 1'b0;
      exp_q.delete();
    end else begin
      if (io_sel && !io_we) exp_q.push_back(m_read(io_addr));
      m_irq = |(m_chg & m_mask);
      m_cm = '0;
      for (int i = 0; i < 4; i++) begin
        if (inp[i] === m_last[i]) m_run[i]++;
        else begin
          m_last[i] = inp[i];
          m_run[i] = 1;
        end
        if (m_run[i] >= LAT && m_last[i] != m_val[i]) begin
          m_val[i] = m_last[i];
          m_cm[i] = 1'b1;
        end
      end
      if (io_sel && io_we) begin
        if (io_addr >= 4 && io_addr < 8) m_otp[io_addr[1:0]] = io_wdata;
        if (io_addr == 9) m_mask = io_wdata[3:0];
        if (io_addr == 8) m_chg = m_chg & ~io_wdata[3:0];
      end
      m_chg = m_chg | m_cm;
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (io_rvalid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got rvalid=1 with data %h, expected no read response", io_rdata);
      end else chk("rdata", io_rdata, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rvalid_missing: got rvalid=0, expected data %h", exp_q[0]);
      exp_q.delete();
    end
    chk("otp0", otp0, m_otp[0]);
    chk("otp1", otp1, m_otp[1]);
    chk("otp2", otp2, m_otp[2]);
    chk("otp3", otp3, m_otp[3]);
    chk("irq", irq, m_irq);
  end

  task automatic cyc(logic sel, logic we, logic [3:0] a, logic [DW-1:0] d);
    @(negedge clock);
    io_sel = sel;
    io_we = we;
    io_addr = a;
    io_wdata = d;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 4'd0, '0);
  endtask

  task automatic rd_now(logic [3:0] a, logic [DW-1:0] exp, string name);
    cyc(1'b1, 1'b0, a, '0);
    @(posedge clock);
    #1;
    chk(name, io_rdata, exp);
    chk({name, "_valid"}, io_rvalid, 1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_otp0", otp0, 0);
    chk("rst_otp1", otp1, 0);
    chk("rst_otp2", otp2, 0);
    chk("rst_otp3", otp3, 0);
    chk("rst_rdata", io_rdata, 0);
    chk("rst_rvalid", io_rvalid, 0);
    chk("rst_irq", irq, 0);
    @(negedge clock);
    resetn = 1'b1;
    rd_now(4'd8, 0, "status_rst");
    cyc(1'b1, 1'b1, 4'd5, 'h12);
    @(posedge clock);
    #1;
    chk("otp1_wr", otp1, 'h12);
    rd_now(4'd5, 'h12, "otp1_rd");
    cyc(1'b1, 1'b1, 4'd2, 'hDEAD);
    rd_now(4'd2, 0, "inp2_ro");
    cyc(1'b1, 1'b0, 4'd2, '0);
    inp[2] = 'h1F;
    repeat (16) cyc(1'b1, 1'b0, 4'd2, '0);
    rd_now(4'd2, 0, "inp2_pre_commit");
    rd_now(4'd2, 'h1F, "inp2_post_commit");
    rd_now(4'd8, 'h4, "chg2_set");
    idle(1);
    inp[0] = 'h3;
    idle(9);
    inp[0] = '0;
    idle(25);
    rd_now(4'd8, 'h4, "glitch_no_chg");
    rd_now(4'd0, 0, "glitch_no_commit");
    idle(1);
    inp[0] = 'h3;
    idle(LAT + 2);
    rd_now(4'd0, 'h3, "inp0_commit");
    rd_now(4'd8, 'h5, "chg0_set");
    cyc(1'b1, 1'b1, 4'd9, 'hFFFF_FFF4);
    @(posedge clock);
    #1;
    chk("irq_lag", irq, 0);
    idle(1);
    @(posedge clock);
    #1;
    chk("irq_set", irq, 1);
    rd_now(4'd9, 'h4, "mask_rd");
    cyc(1'b1, 1'b1, 4'd8, 'h4);
    @(posedge clock);
    #1;
    chk("irq_hold", irq, 1);
    idle(1);
    @(posedge clock);
    #1;
    chk("irq_clr", irq, 0);
    rd_now(4'd8, 'h1, "w1c");
    idle(1);
    inp[2] = 'h0A;
    idle(16);
    cyc(1'b1, 1'b1, 4'd8, 'h4);
    rd_now(4'd8, 'h5, "set_wins");
    rd_now(4'd2, 'h0A, "inp2_second");
    idle(1);
    inp[3] = 'h7;
    idle(8);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_otp1", otp1, 0);
    chk("midrst_irq", irq, 0);
    @(negedge clock);
    resetn = 1'b1;
    rd_now(4'd3, 0, "inp3_after_rst");
    idle(15);
    rd_now(4'd3, 0, "inp3_pre_commit");
    rd_now(4'd3, 'h7, "inp3_post_commit");
    rd_now(4'd9, 0, "mask_after_rst");
    rd_now(4'd12, 0, "unmapped");
    repeat (1500) begin
      logic sel, we;
      logic [3:0] a;
      sel = ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 2) == 0);
      a = 4'($urandom_range(0, 15));
      cyc(sel, we, a, $urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 39) == 0) inp[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
    end
    idle(3);
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending reads, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
